// File: rtl/encoder_snapshot_scheduler_pkg.sv
// enc_sched_pkg: shared types and default widths for the encoder snapshot scheduler
package enc_sched_pkg;
    localparam int CNT_W_DEF  = 32;
    localparam int DEC_W_DEF  = 8;
    localparam int STAT_W_DEF = 16;
    typedef enum logic [1:0] {TRIG_OFF, TRIG_HIGH, TRIG_LOW, TRIG_BOTH} trig_mode_e;
    typedef enum logic [1:0] {S_IDLE, S_WAIT_Z, S_RUN} state_e;
endpackage

// File: rtl/encoder_snapshot_scheduler_rise_detect.sv
// rise_detect: one-cycle pulse on a rising level; history resets to RST_VAL
module rise_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);
    logic prev_q;
    always_ff @(posedge clk) prev_q <= rst ? RST_VAL : d_i;
    assign rise_o = d_i & ~prev_q;
endmodule

// File: rtl/encoder_snapshot_scheduler.sv
// encoder_snapshot_scheduler: carrier-triggered, decimated, index-gated capture of encoder counts with valid/ack handoff
module encoder_snapshot_scheduler
    import enc_sched_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DEC_W  = DEC_W_DEF,
    parameter int STAT_W = STAT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        trig_mode,
    input  logic [DEC_W-1:0]  decim,
    input  logic              require_index,
    input  logic              z_pulse,
    input  logic              carrier_high,
    input  logic              carrier_low,
    input  logic [CNT_W-1:0]  steps_in,
    input  logic [CNT_W-1:0]  position_in,
    output logic [CNT_W-1:0]  steps_synced,
    output logic [CNT_W-1:0]  position_synced,
    output logic              snap_valid,
    input  logic              snap_ack,
    output logic [STAT_W-1:0] snap_seq,
    output logic [STAT_W-1:0] overrun_cnt,
    output logic              capture_strobe,
    output logic              armed
);
    state_e             state_q, state_d;
    logic [DEC_W-1:0]   dcnt_q, dcnt_d;
    logic [CNT_W-1:0]   steps_q, pos_q;
    logic [STAT_W-1:0]  seq_q, ovr_q;
    logic               valid_q, strobe_q;
    logic               rise_h, rise_l, z_rise, ev, fire;
    trig_mode_e         mode;

    rise_detect #(.RST_VAL(1'b1)) u_rh (.clk(clk), .rst(rst), .d_i(carrier_high), .rise_o(rise_h));
    rise_detect #(.RST_VAL(1'b1)) u_rl (.clk(clk), .rst(rst), .d_i(carrier_low),  .rise_o(rise_l));
    rise_detect #(.RST_VAL(1'b1)) u_rz (.clk(clk), .rst(rst), .d_i(z_pulse),      .rise_o(z_rise));

    assign mode = trig_mode_e'(trig_mode);
    assign ev = (mode == TRIG_HIGH && rise_h) || (mode == TRIG_LOW && rise_l) ||
                (mode == TRIG_BOTH && (rise_h || rise_l));

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        fire    = 1'b0;
        if (!enable) begin
            state_d = S_IDLE;
            dcnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE:   state_d = require_index ? S_WAIT_Z : S_RUN;
                S_WAIT_Z: state_d = z_rise ? S_RUN : S_WAIT_Z;
                S_RUN: if (ev) begin
                    fire   = dcnt_q >= decim;
                    dcnt_d = fire ? '0 : dcnt_q + 1'b1;
                end
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            dcnt_q   <= '0;
            steps_q  <= '0;
            pos_q    <= '0;
            seq_q    <= '0;
            ovr_q    <= '0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            strobe_q <= fire;
            valid_q  <= fire | (valid_q & ~snap_ack);
            if (fire) begin
                steps_q <= steps_in;
                pos_q   <= position_in;
                seq_q   <= seq_q + 1'b1;
            end
            // an ack landing with the fire consumes the old snapshot, so it is not an overrun
            if (fire && valid_q && !snap_ack && !(&ovr_q))
                ovr_q <= ovr_q + 1'b1;
        end
    end

    assign steps_synced    = steps_q;
    assign position_synced = pos_q;
    assign snap_valid      = valid_q;
    assign snap_seq        = seq_q;
    assign overrun_cnt     = ovr_q;
    assign capture_strobe  = strobe_q;
    assign armed           = state_q == S_RUN;
endmodule

// File: tb/tb_encoder_snapshot_scheduler.sv
// tb_encoder_snapshot_scheduler: directed checks of triggering, decimation, index gating and handshake
module tb_encoder_snapshot_scheduler;
    logic        clk = 1'b0;
    logic        rst, enable, require_index, z_pulse, carrier_high, carrier_low, snap_ack;
    logic [1:0]  trig_mode;
    logic [7:0]  decim;
    logic [31:0] steps_in, position_in;
    logic [31:0] steps_synced, position_synced, s_steps, s_pos;
    logic [15:0] snap_seq, overrun_cnt;
    logic [1:0]  s_seq, s_ovr;
    logic        snap_valid, capture_strobe, armed, s_valid, s_strobe, s_armed;
    logic        st;
    logic [31:0] held;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    encoder_snapshot_scheduler dut (
        .clk(clk), .rst(rst), .enable(enable), .trig_mode(trig_mode), .decim(decim),
        .require_index(require_index), .z_pulse(z_pulse), .carrier_high(carrier_high),
        .carrier_low(carrier_low), .steps_in(steps_in), .position_in(position_in),
        .steps_synced(steps_synced), .position_synced(position_synced), .snap_valid(snap_valid),
        .snap_ack(snap_ack), .snap_seq(snap_seq), .overrun_cnt(overrun_cnt),
        .capture_strobe(capture_strobe), .armed(armed)
    );

    encoder_snapshot_scheduler #(.STAT_W(2)) u_sat (
        .clk(clk), .rst(rst), .enable(enable), .trig_mode(trig_mode), .decim(decim),
        .require_index(require_index), .z_pulse(z_pulse), .carrier_high(carrier_high),
        .carrier_low(carrier_low), .steps_in(steps_in), .position_in(position_in),
        .steps_synced(s_steps), .position_synced(s_pos), .snap_valid(s_valid),
        .snap_ack(snap_ack), .snap_seq(s_seq), .overrun_cnt(s_ovr),
        .capture_strobe(s_strobe), .armed(s_armed)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic ev(input logic h, input logic l, input logic a, input logic [31:0] s);
        carrier_high = h;
        carrier_low  = l;
        snap_ack     = a;
        steps_in     = s;
        position_in  = ~s;
        cyc(1);
        st           = capture_strobe;
        carrier_high = 1'b0;
        carrier_low  = 1'b0;
        snap_ack     = 1'b0;
        steps_in     = s + 32'h55;
        position_in  = 32'h0;
        cyc(1);
    endtask

    task automatic ack;
        snap_ack = 1'b1;
        cyc(1);
        snap_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; require_index = 1'b0; z_pulse = 1'b0;
        carrier_high = 1'b1; carrier_low = 1'b0; snap_ack = 1'b0;
        trig_mode = 2'd1; decim = 8'd0; steps_in = 32'h0; position_in = 32'h0;
        cyc(2);
        chk("rst_steps", steps_synced, 32'h0);
        chk("rst_valid", {31'b0, snap_valid}, 32'd0);
        chk("rst_seq", {16'b0, snap_seq}, 32'd0);
        chk("rst_ovr", {16'b0, overrun_cnt}, 32'd0);
        chk("rst_armed", {31'b0, armed}, 32'd0);
        rst = 1'b0; enable = 1'b1;
        cyc(1);
        chk("run_armed", {31'b0, armed}, 32'd1);
        cyc(3);
        chk("held_high_no_event", {16'b0, snap_seq}, 32'd0);
        carrier_high = 1'b0;
        cyc(1);
        // mode 1, decim 0: every carrier_high rise captures
        ev(1'b1, 1'b0, 1'b0, 32'h100);
        chk("m1_strobe1", {31'b0, st}, 32'd1);
        chk("m1_steps1", steps_synced, 32'h100);
        chk("m1_pos1", position_synced, ~32'h100);
        chk("m1_valid1", {31'b0, snap_valid}, 32'd1);
        ack;
        chk("ack_clears", {31'b0, snap_valid}, 32'd0);
        ack;
        chk("ack_idle_ignored", {31'b0, snap_valid}, 32'd0);
        ev(1'b0, 1'b1, 1'b0, 32'h150);
        chk("m1_low_ignored", {31'b0, st}, 32'd0);
        ev(1'b1, 1'b0, 1'b0, 32'h200);
        chk("m1_steps2", steps_synced, 32'h200);
        ack;
        cyc(5);
        ev(1'b1, 1'b0, 1'b0, 32'h300);
        chk("m1_strobe3", {31'b0, st}, 32'd1);
        chk("m1_steps3", steps_synced, 32'h300);
        chk("m1_seq", {16'b0, snap_seq}, 32'd3);
        chk("m1_ovr", {16'b0, overrun_cnt}, 32'd0);
        ack;
        trig_mode = 2'd0;
        ev(1'b1, 1'b1, 1'b0, 32'h350);
        chk("m0_no_event", {31'b0, st}, 32'd0);
        // mode 3, decim 2: events 3 and 6 capture; the both-rise counts once
        trig_mode = 2'd3; decim = 8'd2;
        ev(1'b1, 1'b0, 1'b0, 32'h401);
        chk("m3_ev1", {31'b0, st}, 32'd0);
        ev(1'b0, 1'b1, 1'b0, 32'h402);
        chk("m3_ev2", {31'b0, st}, 32'd0);
        ev(1'b1, 1'b0, 1'b0, 32'h403);
        chk("m3_ev3", {31'b0, st}, 32'd1);
        chk("m3_steps3", steps_synced, 32'h403);
        ack;
        ev(1'b1, 1'b1, 1'b0, 32'h404);
        chk("m3_ev4_both", {31'b0, st}, 32'd0);
        ev(1'b0, 1'b1, 1'b0, 32'h405);
        chk("m3_ev5", {31'b0, st}, 32'd0);
        ev(1'b1, 1'b0, 1'b0, 32'h406);
        chk("m3_ev6", {31'b0, st}, 32'd1);
        chk("m3_steps6", steps_synced, 32'h406);
        chk("m3_seq", {16'b0, snap_seq}, 32'd5);
        ack;
        // index gating
        enable = 1'b0;
        cyc(1);
        chk("dis_armed", {31'b0, armed}, 32'd0);
        trig_mode = 2'd1; decim = 8'd0; require_index = 1'b1; enable = 1'b1;
        cyc(1);
        chk("waitz_armed", {31'b0, armed}, 32'd0);
        ev(1'b1, 1'b0, 1'b0, 32'h500);
        chk("waitz_no_cap", {31'b0, st}, 32'd0);
        chk("waitz_held", steps_synced, 32'h406);
        z_pulse = 1'b1;
        cyc(1);
        z_pulse = 1'b0;
        chk("z_armed", {31'b0, armed}, 32'd1);
        ev(1'b1, 1'b0, 1'b0, 32'h600);
        chk("z_cap", steps_synced, 32'h600);
        chk("z_seq", {16'b0, snap_seq}, 32'd6);
        ack;
        // overruns without ack, then ack coincident with a fire
        ev(1'b1, 1'b0, 1'b0, 32'h701);
        ev(1'b1, 1'b0, 1'b0, 32'h702);
        ev(1'b1, 1'b0, 1'b0, 32'h703);
        ev(1'b1, 1'b0, 1'b0, 32'h704);
        chk("ovr_valid", {31'b0, snap_valid}, 32'd1);
        chk("ovr_cnt3", {16'b0, overrun_cnt}, 32'd3);
        chk("ovr_newest", steps_synced, 32'h704);
        ev(1'b1, 1'b0, 1'b1, 32'h705);
        chk("ackfire_valid", {31'b0, snap_valid}, 32'd1);
        chk("ackfire_ovr", {16'b0, overrun_cnt}, 32'd3);
        chk("ackfire_seq", {16'b0, snap_seq}, 32'd11);
        chk("sat_ovr_top", {30'b0, s_ovr}, 32'd3);
        ev(1'b1, 1'b0, 1'b0, 32'h801);
        ev(1'b1, 1'b0, 1'b0, 32'h802);
        ev(1'b1, 1'b0, 1'b0, 32'h803);
        chk("sat_ovr_stuck", {30'b0, s_ovr}, 32'd3);
        chk("ovr_cnt6", {16'b0, overrun_cnt}, 32'd6);
        ack;
        // disable mid-decimation restarts the count
        require_index = 1'b0; decim = 8'd3;
        ev(1'b1, 1'b0, 1'b0, 32'h901);
        chk("dec_ev1", {31'b0, st}, 32'd0);
        held = steps_synced;
        enable = 1'b0;
        cyc(2);
        ev(1'b1, 1'b0, 1'b0, 32'h902);
        chk("dis_no_cap", {31'b0, st}, 32'd0);
        chk("dis_held", steps_synced, held);
        enable = 1'b1;
        cyc(1);
        ev(1'b1, 1'b0, 1'b0, 32'hA01);
        ev(1'b1, 1'b0, 1'b0, 32'hA02);
        ev(1'b1, 1'b0, 1'b0, 32'hA03);
        chk("reen_ev3", {31'b0, st}, 32'd0);
        ev(1'b1, 1'b0, 1'b0, 32'hA04);
        chk("reen_ev4", {31'b0, st}, 32'd1);
        chk("reen_steps", steps_synced, 32'hA04);
        // lowering decim below the count fires on the next event
        ev(1'b1, 1'b0, 1'b0, 32'hB01);
        ev(1'b1, 1'b0, 1'b0, 32'hB02);
        chk("lower_pre", {31'b0, st}, 32'd0);
        decim = 8'd1;
        ev(1'b1, 1'b0, 1'b0, 32'hB03);
        chk("lower_fire", {31'b0, st}, 32'd1);
        chk("final_seq", {16'b0, snap_seq}, 32'd16);
        chk("final_ovr", {16'b0, overrun_cnt}, 32'd7);
        chk("sat_seq_wrap", {30'b0, s_seq}, 32'd0);
        // reset mid-operation
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rst2_steps", steps_synced, 32'h0);
        chk("rst2_ovr", {16'b0, overrun_cnt}, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/encoder_snapshot_scheduler.md
Name: encoder_snapshot_scheduler

Overview:
Sequences when the encoder datapath's instantaneous step count and position are captured into the synced registers read by the control loop. Captures fire on PWM carrier peak/valley events, selected by mode and optionally decimated. Capture can be gated until the first Z index after arming. Each capture is delivered to software through a valid/ack handshake with overrun accounting. Sits between the encoder counter/position datapath, the triangle carrier generator and the AXI register slave.

Parameters:
CNT_W, 32, width of steps/position inputs and synced outputs
DEC_W, 8, width of decimation ratio
STAT_W, 16, width of overrun and sequence counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
enable  in  1  scheduler run enable
trig_mode  in  2  0=off, 1=carrier_high rise, 2=carrier_low rise, 3=either
decim  in  DEC_W  capture every (decim+1)th qualifying event
require_index  in  1  when 1, captures are held off until the first Z after enable rises
z_pulse  in  1  encoder index (Z) level, already synchronised
carrier_high  in  1  carrier peak flag level
carrier_low  in  1  carrier valley flag level
steps_in  in  CNT_W  instantaneous step counter
position_in  in  CNT_W  instantaneous position
steps_synced  out  CNT_W  captured steps
position_synced  out  CNT_W  captured position
snap_valid  out  1  new capture pending
snap_ack  in  1  consumer acknowledge, one-cycle pulse
snap_seq  out  STAT_W  capture sequence number, wraps
overrun_cnt  out  STAT_W  captures that overwrote an un-acked snapshot, saturating
capture_strobe  out  1  one-cycle pulse on each capture
armed  out  1  state is RUN

Behaviour:
- Reset (rst=1 at posedge): all outputs 0; state IDLE; decimation count 0. Edge-detect history registers reset to 1, so a flag already high at reset release is not an event.
- Events: rise_h = carrier_high & ~prev_h; rise_l = carrier_low & ~prev_l; z_rise likewise. History registers update every cycle in every state.
- Qualifying event: mode 1 uses rise_h; mode 2 uses rise_l; mode 3 uses rise_h|rise_l. Simultaneous rise_h and rise_l count as one event. Mode 0 produces no events.
- States:
  - IDLE: enable=1 goes to WAIT_Z if require_index, else RUN.
  - WAIT_Z: z_rise goes to RUN; events are ignored.
  - RUN: armed=1.
  - enable=0 in any state goes to IDLE next cycle and clears the decimation count. Synced outputs, snap_valid, snap_seq and overrun_cnt hold their values.
- Decimation, applied in RUN on each qualifying event:
  - if dcnt >= decim: fire and set dcnt to 0;
  - otherwise dcnt increments.
  - decim=0 fires on every event. Lowering decim below dcnt fires on the next event.
- Fire: in the cycle the event is detected, steps_in/position_in are registered into the synced outputs. They are visible at the following posedge, so latency is 1 clk from event detection. Same edge: capture_strobe=1, snap_seq+1 (modulo 2^STAT_W), snap_valid=1.
- Handshake:
  - snap_ack with snap_valid=1 and no fire clears snap_valid.
  - Fire with snap_valid=1 and no snap_ack in the same cycle: data is overwritten (newest wins), overrun_cnt increments, saturating at all-ones.
  - Fire and snap_ack in the same cycle: snap_valid stays 1, no overrun.
  - snap_ack with snap_valid=0 is ignored.
- Synced outputs never change except on capture_strobe; they are stable between events.
- rst mid-operation overrides everything in the same cycle.

Decomposition:
- Shared package enc_sched_pkg:
  - trig_mode_e enum (TRIG_OFF, TRIG_HIGH, TRIG_LOW, TRIG_BOTH);
  - state_e enum (S_IDLE, S_WAIT_Z, S_RUN);
  - default widths.
- One natural sub-module: rise_detect (parameterised reset value, outputs a one-cycle rise pulse), instantiated three times.

Test Plan:
- Mode 1, decim=0, steps_in ramping, carrier_high rises at cycles 100/300/500 -> three capture_strobes one cycle after each rise; steps_synced equals steps_in at the detect cycle; snap_seq=3.
- Mode 3, decim=2, alternating carrier high/low rises (6 events) -> captures on events 3 and 6 only. A cycle with both rises counts once.
- require_index=1, enable at cycle 10, carrier events before Z -> no capture and armed=0. Z rises at cycle 200 -> armed=1 at 201; next event captures.
- Four captures with no snap_ack -> snap_valid=1, overrun_cnt=3. Ack coincident with a fire -> snap_valid stays 1, overrun_cnt unchanged.
- carrier_high held at 1 through reset release -> no event until it falls and rises again. Force overrun_cnt to 16'hFFFE, then three overruns -> counter sticks at 16'hFFFF.
- enable dropped mid-decimation (dcnt=1, decim=3), then re-enabled -> count restarts; first capture on the 4th event after re-enable. Synced values held while disabled.
